// File: rtl/jpeg_byte_stuffer_if.sv
// FIFO read side, output byte stream and status signals of jpeg_byte_stuffer.
// master = the stuffer itself, slave = its environment (FIFO, sink, controller).
interface jpeg_byte_stuffer_if #(
  parameter int CNT_W = 32
);
  logic             fifo_empty;
  logic [31:0]      read_data;
  logic             rdata_valid;
  logic             read_req;
  logic             flush;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] byte_count;

  modport master (
    input  fifo_empty, read_data, rdata_valid, flush, out_ready,
    output read_req, out_data, out_valid, done, busy, byte_count
  );

  modport slave (
    output fifo_empty, read_data, rdata_valid, flush, out_ready,
    input  read_req, out_data, out_valid, done, busy, byte_count
  );
endinterface

// File: rtl/jpeg_byte_stuffer.sv
// Serialises 32-bit FIFO words MSB first, inserts 0x00 after 0xFF data bytes,
// and appends the EOI marker (FF D9) once a flush has drained the FIFO.
module jpeg_byte_stuffer #(
  parameter bit STUFF_EN = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  jpeg_byte_stuffer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, SEND, STUFF, EOI_FF, EOI_D9, DONE
  } state_t;

  state_t           state_reg;
  logic [1:0]       idx_reg;
  logic [31:0]      word_reg;
  logic             flush_pend_reg;
  logic [CNT_W-1:0] count_reg;
  logic             run_reg;

  logic [7:0] lane [4];
  logic [7:0] out_data;
  logic       out_valid;
  logic       read_req;
  logic       accept;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word_reg[31-8*gi -: 8];
    end
  endgenerate

  // run_reg holds off the first FIFO read until the cycle after reset releases
  assign read_req  = run_reg && (state_reg == IDLE) && !bus.fifo_empty;
  assign out_valid = (state_reg == SEND) || (state_reg == STUFF) ||
                     (state_reg == EOI_FF) || (state_reg == EOI_D9);
  assign accept    = out_valid && bus.out_ready;

  always_comb begin
    out_data = 8'h00;
    case (state_reg)
      SEND:    out_data = lane[idx_reg];
      EOI_FF:  out_data = 8'hFF;
      EOI_D9:  out_data = 8'hD9;
      default: out_data = 8'h00;
    endcase
  end

  assign bus.read_req   = read_req;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.done       = (state_reg == DONE);
  assign bus.busy       = (state_reg != IDLE) || flush_pend_reg;
  assign bus.byte_count = count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      idx_reg        <= 2'd0;
      word_reg       <= 32'h0;
      flush_pend_reg <= 1'b0;
      count_reg      <= '0;
      run_reg        <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (accept) count_reg <= count_reg + CNT_W'(1);

      // a flush on the same cycle as the D9 handshake re-arms the marker
      if (bus.flush)
        flush_pend_reg <= 1'b1;
      else if (state_reg == EOI_D9 && accept)
        flush_pend_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (read_req)            state_reg <= WAIT_DATA;
          else if (flush_pend_reg) state_reg <= EOI_FF;
        end
        WAIT_DATA: begin
          if (bus.rdata_valid) begin
            word_reg  <= bus.read_data;
            idx_reg   <= 2'd0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            if (STUFF_EN && lane[idx_reg] == 8'hFF) begin
              state_reg <= STUFF;
            end else if (idx_reg == 2'd3) begin
              state_reg <= IDLE;
            end else begin
              idx_reg <= idx_reg + 2'd1;
            end
          end
        end
        STUFF: begin
          if (accept) begin
            if (idx_reg == 2'd3) begin
              state_reg <= IDLE;
            end else begin
              idx_reg   <= idx_reg + 2'd1;
              state_reg <= SEND;
            end
          end
        end
        EOI_FF:  if (accept) state_reg <= EOI_D9;
        EOI_D9:  if (accept) state_reg <= DONE;
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Directed bench for jpeg_byte_stuffer: reset, plain and stuffed words, sink stalls,
// flush/EOI sequencing and reset in the middle of a word.
module tb_jpeg_byte_stuffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jpeg_byte_stuffer_if #(.CNT_W(32)) bus0 ();
  jpeg_byte_stuffer_if #(.CNT_W(32)) bus1 ();

  jpeg_byte_stuffer #(.STUFF_EN(1'b1), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  jpeg_byte_stuffer #(.STUFF_EN(1'b0), .CNT_W(32)) dut_raw (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [31:0] fq0 [$];
  logic [31:0] fq1 [$];
  logic [7:0]  got0 [$];
  logic [7:0]  got1 [$];
  int          got0_cyc [$];
  logic        pend0 = 1'b0;
  logic        pend1 = 1'b0;
  logic [31:0] pdata0 = 32'h0;
  logic [31:0] pdata1 = 32'h0;
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_data = 8'h0;
  logic        d9_prev = 1'b0;
  logic [7:0]  last_byte = 8'h0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got0.size() < n && k < budget) begin
      step();
      k++;
    end
    if (got0.size() < n) check_value(tag, 32'(got0.size()), 32'(n));
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [7:0] exp[$]);
    for (int i = 0; i < exp.size(); i++)
      check_value($sformatf("%s_b%0d", tag, i), 32'(got0[base+i]), 32'(exp[i]));
  endtask

  // FIFO model (read data one cycle after read_req) plus output monitor, all at negedge
  initial begin
    bus0.fifo_empty = 1'b1; bus0.rdata_valid = 1'b0; bus0.read_data = 32'h0;
    bus1.fifo_empty = 1'b1; bus1.rdata_valid = 1'b0; bus1.read_data = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      bus0.rdata_valid = pend0; bus0.read_data = pdata0; pend0 = 1'b0;
      bus1.rdata_valid = pend1; bus1.read_data = pdata1; pend1 = 1'b0;
      bus0.fifo_empty = (fq0.size() == 0);
      bus1.fifo_empty = (fq1.size() == 0);
      #1;
      if (rst && bus0.read_req && fq0.size() > 0) begin
        pdata0 = fq0.pop_front();
        pend0  = 1'b1;
      end
      if (rst && bus1.read_req && fq1.size() > 0) begin
        pdata1 = fq1.pop_front();
        pend1  = 1'b1;
      end

      if (rst && stall_prev) begin
        check_value("stall_valid", 32'(bus0.out_valid), 32'd1);
        check_value("stall_data", 32'(bus0.out_data), 32'(stall_data));
      end
      stall_prev = rst && bus0.out_valid && !bus0.out_ready;
      stall_data = bus0.out_data;

      if (d9_prev) check_value("done_after_d9", 32'(bus0.done), 32'd1);
      d9_prev = 1'b0;
      if (bus0.done) done_cnt++;

      if (rst && bus0.out_valid && bus0.out_ready) begin
        got0.push_back(bus0.out_data);
        got0_cyc.push_back(cyc);
        $display("stuffed byte %0d: %02h", got0.size() - 1, bus0.out_data);
        // FF data is always followed by 00, so FF then D9 can only be the marker
        d9_prev   = (bus0.out_data == 8'hD9) && (last_byte == 8'hFF);
        last_byte = bus0.out_data;
      end
      if (rst && bus1.out_valid && bus1.out_ready) begin
        got1.push_back(bus1.out_data);
        $display("raw byte %0d: %02h", got1.size() - 1, bus1.out_data);
      end
    end
  end

  initial begin
    logic [7:0]  exp [$];
    logic [31:0] w;
    logic [7:0]  byt;
    int          base;
    int          k;

    bus0.out_ready = 1'b1; bus0.flush = 1'b0;
    bus1.out_ready = 1'b1; bus1.flush = 1'b0;
    rst = 1'b0;
    fq0.push_back(32'h12345678);
    fq0.push_back(32'hFF00FFAB);
    fq1.push_back(32'hFF00FFAB);

    // reset held for two edges with a non-empty FIFO
    step(); step();
    check_value("rst_read_req", 32'(bus0.read_req), 32'd0);
    check_value("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check_value("rst_out_data", 32'(bus0.out_data), 32'd0);
    check_value("rst_byte_count", bus0.byte_count, 32'd0);
    check_value("rst_busy", 32'(bus0.busy), 32'd0);
    check_value("rst_done", 32'(bus0.done), 32'd0);
    rst = 1'b1;
    check_value("release_read_req", 32'(bus0.read_req), 32'd0);
    step();
    check_value("first_read_req", 32'(bus0.read_req), 32'd1);

    // plain word
    wait_bytes(4, 40, "plain_timeout");
    exp = '{8'h12, 8'h34, 8'h56, 8'h78};
    check_bytes("plain", 0, exp);
    check_value("plain_back_to_back", 32'(got0_cyc[3] - got0_cyc[0]), 32'd3);
    check_value("plain_count", bus0.byte_count, 32'd4);
    check_value("plain_next_read", 32'(bus0.read_req), 32'd1);

    // stuffed word, and the same word through the non-stuffing instance
    wait_bytes(10, 40, "stuff_timeout");
    exp = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAB};
    check_bytes("stuff", 4, exp);
    check_value("stuff_count", bus0.byte_count, 32'd10);
    k = 0;
    while (got1.size() < 4 && k < 40) begin step(); k++; end
    check_value("raw_len", 32'(got1.size()), 32'd4);
    check_value("raw_b0", 32'(got1[0]), 32'hFF);
    check_value("raw_b1", 32'(got1[1]), 32'h00);
    check_value("raw_b2", 32'(got1[2]), 32'hFF);
    check_value("raw_b3", 32'(got1[3]), 32'hAB);
    check_value("raw_count", bus1.byte_count, 32'd4);

    // 16 words with random sink stalls
    base = got0.size();
    exp.delete();
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      if (i % 3 == 0) w[15:8] = 8'hFF;
      if (i == 5) w = 32'hFFFFFFFF;
      fq0.push_back(w);
      for (int b = 3; b >= 0; b--) begin
        byt = w[8*b +: 8];
        exp.push_back(byt);
        if (byt == 8'hFF) exp.push_back(8'h00);
      end
    end
    k = 0;
    while (got0.size() < base + exp.size() && k < 2000) begin
      bus0.out_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    bus0.out_ready = 1'b1;
    if (got0.size() < base + exp.size())
      check_value("stall_timeout", 32'(got0.size()), 32'(base + exp.size()));
    check_bytes("stall", base, exp);
    step(); step();
    check_value("stall_count", bus0.byte_count, 32'(got0.size()));

    // flush with three words queued
    base = got0.size();
    fq0.push_back(32'h11223344);
    fq0.push_back(32'h55667788);
    fq0.push_back(32'h99AABBCC);
    bus0.flush = 1'b1;
    step();
    bus0.flush = 1'b0;
    check_value("flush_busy", 32'(bus0.busy), 32'd1);
    wait_bytes(base + 14, 300, "flush_timeout");
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
            8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hFF, 8'hD9};
    check_bytes("flush", base, exp);
    step(); step();
    check_value("flush_done_count", 32'(done_cnt), 32'd1);
    check_value("flush_done_low", 32'(bus0.done), 32'd0);
    check_value("flush_busy_after", 32'(bus0.busy), 32'd0);
    check_value("flush_count", bus0.byte_count, 32'(got0.size()));

    // reset while the stuffing byte is pending
    base = got0.size();
    fq0.push_back(32'hABFF0102);
    wait_bytes(base + 2, 40, "midrst_timeout");
    check_value("midrst_b0", 32'(got0[base]), 32'hAB);
    check_value("midrst_b1", 32'(got0[base+1]), 32'hFF);
    check_value("midrst_stuff_data", 32'(bus0.out_data), 32'h00);
    rst = 1'b0;
    step();
    check_value("midrst_out_valid", 32'(bus0.out_valid), 32'd0);
    check_value("midrst_count", bus0.byte_count, 32'd0);
    check_value("midrst_busy", 32'(bus0.busy), 32'd0);
    check_value("midrst_no_extra", 32'(got0.size()), 32'(base + 2));
    rst = 1'b1;
    base = got0.size();
    fq0.push_back(32'h01020304);
    wait_bytes(base + 4, 40, "after_rst_timeout");
    step(); step();
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_bytes("after_rst", base, exp);
    check_value("after_rst_len", 32'(got0.size()), 32'(base + 4));
    check_value("after_rst_count", bus0.byte_count, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
